regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_writeback_fwd_match.sv | 26 ++
 rtl/regfile_writeback.sv | 120 ++++++++++++
 tb/tb_regfile_writeback.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions and the pending-write entry type used by
// the writeback queue.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_entry_t;

  // Register 0 is hardwired zero, so a result targeting it never needs a write.
  function automatic logic writes_reg(input logic valid, input reg_addr_t rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/regfile_writeback_fwd_match.sv
// Youngest-match search over the pending-write entries for one read port.
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  [DEPTH-1:0] valid,
  input  wb_entry_t [DEPTH-1:0]             entries,
  input  reg_addr_t                         read_reg,
  output logic                              hit,
  output reg_data_t                         data
);

  // Entries arrive oldest first, so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].rd == read_reg) && (read_reg != '0)) begin
        hit  = 1'b1;
        data = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// In-order writeback queue merging ALU and multdiv results into a single
// register-file write port, with forwarding of still-pending values.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    md_valid,
  input  logic [REG_ADDR_W-1:0]   md_rd,
  input  logic [DATA_W-1:0]       md_data,
  output logic                    in_ready,
  output logic                    ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]       data_writeReg,
  input  logic [REG_ADDR_W-1:0]   ctrl_readRegA,
  input  logic [REG_ADDR_W-1:0]   ctrl_readRegB,
  output logic                    fwd_hitA,
  output logic                    fwd_hitB,
  output logic [DATA_W-1:0]       fwd_dataA,
  output logic [DATA_W-1:0]       fwd_dataB,
  output logic [$clog2(DEPTH):0]  pending_count,
  output logic                    overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     free_slots;
  logic [CNT_W-1:0]     n_acc;
  logic                 md_ok;
  logic                 alu_ok;
  logic                 take_md;
  logic                 take_alu;
  logic                 take_first;
  logic                 take_second;
  logic                 pop;
  logic                 overflow_hit;
  wb_entry_t            first_entry;
  wb_entry_t            second_entry;
  logic      [DEPTH-1:0] age_valid;
  wb_entry_t [DEPTH-1:0] age_entries;

  // Admission looks only at the current occupancy; a same-edge pop does not
  // create room, so md claims the last free slot ahead of alu.
  always_comb begin
    free_slots   = CNT_W'(DEPTH) - count;
    in_ready     = free_slots >= CNT_W'(2);
    md_ok        = writes_reg(md_valid, md_rd);
    alu_ok       = writes_reg(alu_valid, alu_rd);
    take_md      = md_ok && (free_slots != '0);
    take_alu     = alu_ok && (in_ready || (!md_ok && (free_slots != '0)));
    take_first   = take_md || take_alu;
    take_second  = take_md && take_alu;
    n_acc        = CNT_W'(take_md) + CNT_W'(take_alu);
    pop          = count != '0;
    overflow_hit = !in_ready && (md_ok || alu_ok);
    first_entry  = take_md ? '{rd: md_rd, data: md_data} : '{rd: alu_rd, data: alu_data};
    second_entry = '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      head         <= head + PTR_W'(pop);
      tail         <= tail + PTR_W'(n_acc);
      count        <= count + n_acc - CNT_W'(pop);
      overflow_err <= overflow_err | overflow_hit;
    end
  end

  always_ff @(posedge clock) begin
    if (take_first)  mem[tail] <= first_entry;
    if (take_second) mem[tail + PTR_W'(1)] <= second_entry;
  end

  always_comb begin
    ctrl_writeEnable = pop;
    ctrl_writeReg    = pop ? mem[head].rd   : '0;
    data_writeReg    = pop ? mem[head].data : '0;
    pending_count    = count;
  end

  // Present the circular buffer to the matchers in age order (index 0 = head).
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_entries[i] = mem[head + PTR_W'(i)];
      age_valid[i]   = CNT_W'(i) < count;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
    .valid    (age_valid),
    .entries  (age_entries),
    .read_reg (ctrl_readRegA),
    .hit      (fwd_hitA),
    .data     (fwd_dataA)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
    .valid    (age_valid),
    .entries  (age_entries),
    .read_reg (ctrl_readRegB),
    .hit      (fwd_hitB),
    .data     (fwd_dataB)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clock;
  logic        ctrl_reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        in_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;
  logic [2:0]  pending_count;
  logic        overflow_err;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .in_ready         (in_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .fwd_hitA         (fwd_hitA),
    .fwd_hitB         (fwd_hitB),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB),
    .pending_count    (pending_count),
    .overflow_err     (overflow_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   tests;
  int   fails;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  // Drives one cycle of offers, advances the reference model across the edge,
  // then withdraws the offers 1ns after the edge.
  task automatic step(input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input bit av, input logic [4:0] ard, input logic [31:0] adat);
    int free;
    bit rdy;
    md_valid = mv;  md_rd = mrd;  md_data = mdat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    @(posedge clock);
    free = DEPTH - q.size();
    rdy  = free >= 2;
    if (q.size() > 0) void'(q.pop_front());
    if (!rdy && ((mv && mrd != 0) || (av && ard != 0))) m_ovf = 1'b1;
    if (mv && mrd != 0 && free > 0) begin
      q.push_back('{rd: mrd, data: mdat});
      free--;
    end
    if (av && ard != 0 && free > 0) q.push_back('{rd: ard, data: adat});
    #1;
    md_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    #12;
    tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", ctrl_writeEnable); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", pending_count); end
    tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", overflow_err); end
    tests++; if (fwd_hitA !== 1'b0 || fwd_hitB !== 1'b0) begin fails++; $display("FAIL reset_fwd: got %b%b expected 00", fwd_hitA, fwd_hitB); end
    ctrl_reset_n = 1'b1;
    @(posedge clock); #1;
    tests++; if (ctrl_writeEnable !== 1'b0 || pending_count !== 3'd0) begin fails++; $display("FAIL post_reset_idle: we=%b count=%0d expected 0 0", ctrl_writeEnable, pending_count); end
  endtask

  task automatic test_single();
    step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    tests++; if (ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL single_we: got %b expected 1", ctrl_writeEnable); end
    tests++; if (ctrl_writeReg !== 5'd5) begin fails++; $display("FAIL single_reg: got %0d expected 5", ctrl_writeReg); end
    tests++; if (data_writeReg !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h expected deadbeef", data_writeReg); end
    tests++; if (pending_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", pending_count); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (ctrl_writeEnable !== 1'b0 || pending_count !== 3'd0) begin fails++; $display("FAIL single_drain: we=%b count=%0d expected 0 0", ctrl_writeEnable, pending_count); end
    tests++; if (ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin fails++; $display("FAIL empty_zero: reg=%0d data=%h expected 0 0", ctrl_writeReg, data_writeReg); end
  endtask

  task automatic test_dual();
    step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    tests++; if (pending_count !== 3'd2) begin fails++; $display("FAIL dual_count0: got %0d expected 2", pending_count); end
    tests++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h11) begin fails++; $display("FAIL dual_first: reg=%0d data=%h expected 3 11", ctrl_writeReg, data_writeReg); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (pending_count !== 3'd1) begin fails++; $display("FAIL dual_count1: got %0d expected 1", pending_count); end
    tests++; if (ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h22) begin fails++; $display("FAIL dual_second: reg=%0d data=%h expected 4 22", ctrl_writeReg, data_writeReg); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (pending_count !== 3'd0) begin fails++; $display("FAIL dual_count2: got %0d expected 0", pending_count); end
  endtask

  task automatic test_forward();
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd0;
    step(1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
    tests++; if (fwd_hitA !== 1'b1 || fwd_dataA !== 32'hB) begin fails++; $display("FAIL fwd_young: hit=%b data=%h expected 1 b", fwd_hitA, fwd_dataA); end
    tests++; if (fwd_hitB !== 1'b0 || fwd_dataB !== 32'd0) begin fails++; $display("FAIL fwd_r0: hit=%b data=%h expected 0 0", fwd_hitB, fwd_dataB); end
    ctrl_readRegB = 5'd7;
    #1;
    tests++; if (fwd_hitB !== 1'b1 || fwd_dataB !== 32'hB) begin fails++; $display("FAIL fwd_b: hit=%b data=%h expected 1 b", fwd_hitB, fwd_dataB); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (fwd_hitA !== 1'b1 || fwd_dataA !== 32'hB) begin fails++; $display("FAIL fwd_head: hit=%b data=%h expected 1 b", fwd_hitA, fwd_dataA); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (fwd_hitA !== 1'b0 || fwd_dataA !== 32'd0) begin fails++; $display("FAIL fwd_gone: hit=%b data=%h expected 0 0", fwd_hitA, fwd_dataA); end
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
  endtask

  task automatic test_rd_zero();
    step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    tests++; if (pending_count !== 3'd0 || ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL rd0_drop: count=%0d we=%b expected 0 0", pending_count, ctrl_writeEnable); end
    step(1, 5'd0, 32'h1, 1, 5'd9, 32'h99);
    tests++; if (pending_count !== 3'd1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h99) begin fails++; $display("FAIL rd0_mixed: count=%0d reg=%0d data=%h expected 1 9 99", pending_count, ctrl_writeReg, data_writeReg); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    step(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
    tests++; if (pending_count !== 3'd2 || in_ready !== 1'b1) begin fails++; $display("FAIL ovf_fill1: count=%0d rdy=%b expected 2 1", pending_count, in_ready); end
    step(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);
    tests++; if (pending_count !== 3'd3 || in_ready !== 1'b0 || overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_fill2: count=%0d rdy=%b ovf=%b expected 3 0 0", pending_count, in_ready, overflow_err); end
    step(1, 5'd5, 32'h105, 1, 5'd6, 32'h106);
    tests++; if (pending_count !== 3'd3 || overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_set: count=%0d ovf=%b expected 3 1", pending_count, overflow_err); end
    tests++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h103) begin fails++; $display("FAIL ovf_head: reg=%0d data=%h expected 3 103", ctrl_writeReg, data_writeReg); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (ctrl_writeReg !== 5'd4 || in_ready !== 1'b1) begin fails++; $display("FAIL ovf_next: reg=%0d rdy=%b expected 4 1", ctrl_writeReg, in_ready); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (ctrl_writeReg !== 5'd5 || data_writeReg !== 32'h105) begin fails++; $display("FAIL ovf_md_kept: reg=%0d data=%h expected 5 105", ctrl_writeReg, data_writeReg); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (ctrl_writeEnable !== 1'b0 || overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: we=%b ovf=%b expected 0 1", ctrl_writeEnable, overflow_err); end
  endtask

  task automatic test_random();
    bit          exp_hit_a, exp_hit_b;
    logic [31:0] exp_dat_a, exp_dat_b;
    for (int n = 0; n < 250; n++) begin
      ctrl_readRegA = 5'($urandom_range(0, 7));
      ctrl_readRegB = 5'($urandom_range(0, 7));
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      exp_hit_a = 1'b0; exp_dat_a = '0;
      exp_hit_b = 1'b0; exp_dat_b = '0;
      foreach (q[k]) begin
        if (ctrl_readRegA != 0 && q[k].rd == ctrl_readRegA) begin exp_hit_a = 1'b1; exp_dat_a = q[k].data; end
        if (ctrl_readRegB != 0 && q[k].rd == ctrl_readRegB) begin exp_hit_b = 1'b1; exp_dat_b = q[k].data; end
      end
      tests++; if (pending_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, pending_count, q.size()); end
      tests++; if (in_ready !== (DEPTH - q.size() >= 2)) begin fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, in_ready, DEPTH - q.size() >= 2); end
      tests++; if (overflow_err !== m_ovf) begin fails++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, overflow_err, m_ovf); end
      if (q.size() > 0) begin
        tests++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== q[0].rd || data_writeReg !== q[0].data) begin fails++; $display("FAIL rnd_write@%0d: we=%b reg=%0d data=%h expected 1 %0d %h", n, ctrl_writeEnable, ctrl_writeReg, data_writeReg, q[0].rd, q[0].data); end
      end else begin
        tests++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin fails++; $display("FAIL rnd_idle@%0d: we=%b reg=%0d data=%h expected 0 0 0", n, ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
      end
      tests++; if (fwd_hitA !== exp_hit_a || fwd_dataA !== exp_dat_a) begin fails++; $display("FAIL rnd_fwdA@%0d: hit=%b data=%h expected %b %h", n, fwd_hitA, fwd_dataA, exp_hit_a, exp_dat_a); end
      tests++; if (fwd_hitB !== exp_hit_b || fwd_dataB !== exp_dat_b) begin fails++; $display("FAIL rnd_fwdB@%0d: hit=%b data=%h expected %b %h", n, fwd_hitB, fwd_dataB, exp_hit_b, exp_dat_b); end
    end
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
  endtask

  task automatic test_reset_mid();
    while (q.size() > 0) step(0, 0, 0, 0, 0, 0);
    step(1, 5'd12, 32'h12, 1, 5'd13, 32'h13);
    step(1, 5'd14, 32'h14, 1, 5'd15, 32'h15);
    tests++; if (pending_count !== 3'd3) begin fails++; $display("FAIL mid_setup: count=%0d expected 3", pending_count); end
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    tests++; if (pending_count !== 3'd0 || ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL mid_async: count=%0d we=%b expected 0 0", pending_count, ctrl_writeEnable); end
    tests++; if (overflow_err !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_flags: ovf=%b rdy=%b expected 0 1", overflow_err, in_ready); end
    @(posedge clock); #1;
    ctrl_reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step(0, 0, 0, 0, 0, 0);
      tests++; if (ctrl_writeEnable !== 1'b0 || pending_count !== 3'd0) begin fails++; $display("FAIL mid_no_write@%0d: we=%b count=%0d expected 0 0", n, ctrl_writeEnable, pending_count); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    md_valid = 1'b0;  md_rd = '0;  md_data = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    test_reset();
    test_single();
    test_dual();
    test_forward();
    test_rd_zero();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
